hs_angle_dispatcher: RTL and testbench

Scheduler between the host angle source and a bank of NUM_PE back-projection processing elements (PEs).
- After a start pulse, pulls angles from the source over its next/ack handshake.
- Hands each angle to a free PE in round-robin order and tracks per-PE busy state.
- Pulses done once the source is exhausted and every PE has finished.

---
 rtl/hs_angle_dispatcher.sv | 76 +++++++
 tb/tb_hs_angle_dispatcher.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_angle_dispatcher.sv
// hs_angle_dispatcher: pulls angles from the host source and hands each one to a free PE in round-robin order.
// Ports: clk/reset_n (async active-low); start begins a pass; hs_next_angle/hs_next_angle_ack/hs_has_next_angle/hs_angle
// form the source handshake (angle valid the cycle after ack); pe_angle/pe_start dispatch one angle to one PE;
// pe_done clears a PE's busy flag; pe_busy, running, done and angle_count report progress.
module hs_angle_dispatcher #(
  parameter int NUM_PE      = 4,
  parameter int ANGLE_WIDTH = 9,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   hs_next_angle,
  input  logic                   hs_next_angle_ack,
  input  logic                   hs_has_next_angle,
  input  logic [ANGLE_WIDTH-1:0] hs_angle,
  output logic [ANGLE_WIDTH-1:0] pe_angle,
  output logic [NUM_PE-1:0]      pe_start,
  input  logic [NUM_PE-1:0]      pe_done,
  output logic [NUM_PE-1:0]      pe_busy,
  output logic                   running,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] angle_count
);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, DISPATCH, DRAIN, FINISH} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr_ptr, sel, idx;
  logic [NUM_PE-1:0] busy_nx;
  // Walk offsets high to low so the smallest offset from rr_ptr with a free PE wins.
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_PE);
      if (!pe_busy[idx]) sel = idx;
    end
  end
  always_comb begin
    pe_start      = (state == DISPATCH) ? NUM_PE'(1) << sel : '0;
    hs_next_angle = (state == FETCH) && hs_has_next_angle && !(&pe_busy);
    busy_nx       = (pe_busy & ~pe_done) | pe_start;
    running       = state != IDLE;
    done          = state == FINISH;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = start ? FETCH : IDLE;
      FETCH:    state_nx = !hs_has_next_angle ? DRAIN : hs_next_angle_ack ? LATCH : FETCH;
      LATCH:    state_nx = DISPATCH;
      DISPATCH: state_nx = FETCH;
      DRAIN:    state_nx = (busy_nx == '0) ? FINISH : DRAIN;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      pe_busy     <= '0;
      pe_angle    <= '0;
      angle_count <= '0;
    end else begin
      state   <= state_nx;
      pe_busy <= busy_nx;
      if (state == IDLE && start) angle_count <= '0;
      if (state == LATCH) pe_angle <= hs_angle;
      if (state == DISPATCH) begin
        rr_ptr      <= (sel == PW'(NUM_PE - 1)) ? '0 : sel + PW'(1);
        angle_count <= angle_count + COUNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_hs_angle_dispatcher.sv
// tb_hs_angle_dispatcher: scoreboard bench with source and PE models for hs_angle_dispatcher.
module tb_hs_angle_dispatcher;
  localparam int N = 4, AW = 9, CW = 8;
  logic clk = 0, reset_n = 0, start = 0, hs_has_next_angle = 0;
  logic hs_next_angle, hs_next_angle_ack, running, done;
  logic [AW-1:0] hs_angle = '0, pe_angle;
  logic [N-1:0] pe_start, pe_busy, pe_done = '0;
  logic [CW-1:0] angle_count;
  always #5 clk = ~clk;
  assign hs_next_angle_ack = hs_next_angle && hs_has_next_angle;
  hs_angle_dispatcher #(.NUM_PE(N), .ANGLE_WIDTH(AW), .COUNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .hs_next_angle(hs_next_angle), .hs_next_angle_ack(hs_next_angle_ack),
    .hs_has_next_angle(hs_has_next_angle), .hs_angle(hs_angle),
    .pe_angle(pe_angle), .pe_start(pe_start), .pe_done(pe_done), .pe_busy(pe_busy),
    .running(running), .done(done), .angle_count(angle_count)
  );
  int vectors = 0, errors = 0, cyc = 0;
  int src_q[$], exp_q[$], hold_q[$], disp_q[$], disp_t[$];
  int timer[N];
  int hold = 10, m_rr = 0, m_cnt = 0, n_done = 0, n_req = 0;
  int t_start = 0, t_done = 0, t_last_pd = 0, t_pd0 = -1;
  logic [N-1:0] m_busy = '0;
  bit ack_pend = 0, rst_arm = 0, rst_hit = 0, prev_done = 0;

  function automatic int first_free(logic [N-1:0] b, int r);
    for (int k = 0; k < N; k++)
      if (!b[(r + k) % N]) return (r + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    logic [N-1:0] exp_start, pd;
    int pick, a;
    exp_start = '0;
    @(negedge clk);
    vectors++;
    if (pe_busy !== m_busy) begin errors++; $display("FAIL busy cyc%0d: got %b expected %b", cyc, pe_busy, m_busy); end
    if (rst_arm && |pe_start) begin
      #1 reset_n = 0;
      #1;
      vectors++;
      if ({hs_next_angle, pe_start, running, done} !== '0) begin
        errors++; $display("FAIL async_reset_ctl: got req=%b start=%b run=%b done=%b expected all 0", hs_next_angle, pe_start, running, done);
      end
      vectors++;
      if ({pe_angle, pe_busy, angle_count} !== '0) begin
        errors++; $display("FAIL async_reset_regs: got angle=%0d busy=%b count=%0d expected 0", pe_angle, pe_busy, angle_count);
      end
      rst_arm = 0; rst_hit = 1; m_busy = '0; m_rr = 0; m_cnt = 0; exp_q.delete(); ack_pend = 0;
      for (int i = 0; i < N; i++) timer[i] = 0;
    end else begin
      if (|pe_done) t_last_pd = cyc;
      if (pe_done[0] && t_pd0 < 0) t_pd0 = cyc;
      if (hs_next_angle) n_req++;
      if (&m_busy || !hs_has_next_angle) begin
        vectors++;
        if (hs_next_angle !== 1'b0) begin errors++; $display("FAIL req_gate cyc%0d: got %b expected 0 (busy=%b has=%b)", cyc, hs_next_angle, m_busy, hs_has_next_angle); end
      end
      if (|pe_start) begin
        pick = first_free(m_busy, m_rr);
        if (pick >= 0) exp_start[pick] = 1'b1;
        vectors++;
        if (pe_start !== exp_start) begin errors++; $display("FAIL pe_start cyc%0d: got %b expected %b", cyc, pe_start, exp_start); end
        vectors++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL pe_angle cyc%0d: got %0d expected none", cyc, pe_angle); end
        else begin
          a = exp_q.pop_front();
          if (pe_angle !== AW'(a)) begin errors++; $display("FAIL pe_angle cyc%0d: got %0d expected %0d", cyc, pe_angle, a); end
        end
        if (pick >= 0) begin
          timer[pick] = (hold_q.size() != 0) ? hold_q.pop_front() : hold;
          m_rr = (pick + 1) % N;
        end
        m_cnt++;
        disp_q.push_back(pick);
        disp_t.push_back(cyc);
      end
      if (done) begin
        vectors++;
        if (prev_done) begin errors++; $display("FAIL done_width cyc%0d: got 1 expected 0", cyc); end
        n_done++; t_done = cyc;
      end
      prev_done = done;
      if (hs_next_angle_ack && src_q.size() != 0) begin exp_q.push_back(src_q[0]); ack_pend = 1; end
      m_busy = (m_busy & ~pe_done) | exp_start;
    end
    @(posedge clk);
    #1;
    cyc++;
    start = 0;
    if (ack_pend) begin hs_angle = AW'(src_q.pop_front()); ack_pend = 0; end
    hs_has_next_angle = src_q.size() != 0;
    pd = '0;
    for (int i = 0; i < N; i++)
      if (timer[i] > 0) begin
        timer[i]--;
        if (timer[i] == 0) pd[i] = 1'b1;
      end
    pe_done = pd;
  endtask

  task automatic begin_pass();
    hs_has_next_angle = src_q.size() != 0;
    start = 1; m_cnt = 0; t_start = cyc; n_req = 0;
    disp_q.delete(); disp_t.delete();
  endtask

  task automatic run_pass(int budget, string name);
    int n0 = n_done, i = 0;
    while (n_done == n0 && i < budget) begin cycle(); i++; end
    vectors++;
    if (n_done == n0) begin errors++; $display("FAIL %s_timeout: got no done within %0d cycles expected done", name, budget); end
    vectors++;
    if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s_idle: got run=%b done=%b expected 0 0", name, running, done); end
    vectors++;
    if (angle_count !== CW'(m_cnt)) begin errors++; $display("FAIL %s_count: got %0d expected %0d", name, angle_count, m_cnt); end
    vectors++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_scoreboard: got %0d left expected 0", name, exp_q.size()); end
  endtask

  task automatic test_reset();
    repeat (3) cycle();
    vectors++;
    if ({hs_next_angle, pe_start, running, done} !== '0) begin errors++; $display("FAIL reset_ctl: got req=%b start=%b run=%b done=%b expected 0", hs_next_angle, pe_start, running, done); end
    vectors++;
    if ({pe_angle, pe_busy, angle_count} !== '0) begin errors++; $display("FAIL reset_regs: got angle=%0d busy=%b count=%0d expected 0", pe_angle, pe_busy, angle_count); end
    reset_n = 1;
    cycle();
    vectors++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_idle: got running=%b expected 0", running); end
  endtask

  task automatic test_basic();
    int eo[$];
    eo = {0, 1, 2, 3};
    hold = 10; src_q = {0, 45, 90, 135};
    begin_pass();
    run_pass(200, "basic");
    vectors++;
    if (disp_q != eo) begin errors++; $display("FAIL basic_order: got %p expected %p", disp_q, eo); end
    vectors++;
    if (disp_t.size() == 0 || disp_t[0] != t_start + 3) begin errors++; $display("FAIL basic_latency: got first dispatch %p expected cycle %0d", disp_t, t_start + 3); end
    vectors++;
    if (t_done != t_last_pd + 1) begin errors++; $display("FAIL basic_done_time: got %0d expected %0d", t_done, t_last_pd + 1); end
    vectors++;
    if (angle_count !== 8'd4) begin errors++; $display("FAIL basic_count: got %0d expected 4", angle_count); end
  endtask

  task automatic test_stall();
    int eo[$];
    eo = {0, 1, 2, 3, 0, 1, 2, 3};
    hold = 30; src_q = {10, 20, 30, 40, 50, 60, 70, 80}; t_pd0 = -1;
    begin_pass();
    run_pass(400, "stall");
    vectors++;
    if (disp_q != eo) begin errors++; $display("FAIL stall_order: got %p expected %p", disp_q, eo); end
    vectors++;
    if (disp_t.size() < 5 || t_pd0 < 0 || disp_t[4] <= t_pd0) begin errors++; $display("FAIL stall_wait: got 5th dispatch %p expected after pe_done0 at %0d", disp_t, t_pd0); end
  endtask

  task automatic test_out_of_order();
    int eo[$];
    eo = {0, 1, 2, 3, 0, 2, 2};
    hold = 5; hold_q = {4, 80, 4, 80, 80, 10, 5};
    src_q = {100, 101, 102, 103, 104, 105, 106};
    begin_pass();
    run_pass(400, "ooo");
    vectors++;
    if (disp_q != eo) begin errors++; $display("FAIL ooo_order: got %p expected %p", disp_q, eo); end
  endtask

  task automatic test_empty();
    src_q.delete();
    begin_pass();
    run_pass(20, "empty");
    vectors++;
    if (t_done != t_start + 3) begin errors++; $display("FAIL empty_done_time: got %0d expected %0d", t_done, t_start + 3); end
    vectors++;
    if (n_req != 0 || disp_q.size() != 0) begin errors++; $display("FAIL empty_req: got %0d requests %0d dispatches expected 0 0", n_req, disp_q.size()); end
  endtask

  task automatic test_start_in_drain();
    int i = 0, n0;
    logic [N-1:0] spur;
    hold = 20; src_q = {300, 511};
    begin_pass();
    while (disp_q.size() < 2 && i < 50) begin cycle(); i++; end
    repeat (3) cycle();
    spur = '0;
    for (int k = N - 1; k >= 0; k--) if (!m_busy[k]) spur = N'(1) << k;
    n0 = n_done;
    start = 1;
    pe_done = pe_done | spur;
    run_pass(100, "drain");
    repeat (6) cycle();
    vectors++;
    if (n_done != n0 + 1) begin errors++; $display("FAIL drain_done_count: got %0d expected %0d", n_done - n0, 1); end
    vectors++;
    if (angle_count !== 8'd2 || running !== 1'b0) begin errors++; $display("FAIL drain_final: got count=%0d run=%b expected 2 0", angle_count, running); end
  endtask

  task automatic test_reset_mid_pass();
    int i = 0, n0;
    int eo[$];
    eo = {0, 1, 2, 3};
    hold = 10; src_q = {1, 2, 3, 4};
    rst_arm = 1; rst_hit = 0;
    begin_pass();
    while (!rst_hit && i < 30) begin cycle(); i++; end
    vectors++;
    if (!rst_hit) begin errors++; $display("FAIL midreset_hit: got no dispatch expected one"); rst_arm = 0; end
    n0 = n_done;
    repeat (3) cycle();
    reset_n = 1;
    cycle();
    vectors++;
    if (n_done != n0 || running !== 1'b0) begin errors++; $display("FAIL midreset_quiet: got done=%0d run=%b expected 0 0", n_done - n0, running); end
    src_q = {7, 8, 9, 10};
    begin_pass();
    run_pass(200, "midreset");
    vectors++;
    if (disp_q != eo) begin errors++; $display("FAIL midreset_order: got %p expected %p", disp_q, eo); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) timer[i] = 0;
    test_reset();
    test_basic();
    test_stall();
    test_out_of_order();
    test_empty();
    test_start_in_drain();
    test_reset_mid_pass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
